// File: rtl/dec3_8_seq.sv
// dec3_8_seq: sequencing 3-to-8 decoder.
// Codes {valid, index[2:0]} are queued in a 2-entry FIFO and each one is
// shown on O as a one-hot pattern for HOLD cycles, in arrival order.
// Optional feature: define DEC3_8_GAP_EN to insert one all-zero cycle on O
// between consecutive codes. Without it, codes are shown back-to-back.
module dec3_8_seq #(
  parameter int HOLD = 2  // cycles each one-hot pattern is held, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Y,
  output logic       ready,
  output logic [7:0] O,
  output logic       busy,
  output logic [7:0] cnt
);

`ifdef DEC3_8_GAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD} state_t;
`endif

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [7:0]  o_q, o_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  count_q, count_d;
  logic [2:0]  head_q, head_d;
  logic [2:0]  tail_q, tail_d;
  logic        push;
  logic        pop;

  // ready depends on registered occupancy only, so Y never reaches it.
  assign ready = (count_q != 2'd2);
  assign push  = Y[3] && ready;
  assign O     = o_q;
  assign cnt   = cnt_q;
  assign busy  = (state_q != ST_IDLE) || (count_q != 2'd0);

  // Next-state, output pattern and pop decision for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    hold_d  = hold_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pop = (count_q != 2'd0);
      end
      ST_HOLD: begin
        if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else begin
`ifdef DEC3_8_GAP_EN
          state_d = ST_GAP;
          o_d     = 8'h00;
`else
          // Chain straight into the next code when one is waiting.
          state_d = ST_IDLE;
          o_d     = 8'h00;
          pop     = (count_q != 2'd0);
`endif
        end
      end
`ifdef DEC3_8_GAP_EN
      ST_GAP: begin
        // The blank cycle has been shown; act exactly like IDLE now.
        state_d = ST_IDLE;
        pop     = (count_q != 2'd0);
      end
`endif
      default: begin
        state_d = ST_IDLE;
        o_d     = 8'h00;
      end
    endcase
    if (pop) begin
      state_d = ST_HOLD;
      o_d     = 8'h01 << head_q;
      hold_d  = HOLD_LOAD;
      cnt_d   = cnt_q + 8'd1;
    end
  end

  // FIFO occupancy and payload update for push, pop or both at once.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = Y[2:0];
        else                 tail_d = Y[2:0];
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Both together only happen with one entry: it leaves, Y takes its place.
      2'b11: head_d = Y[2:0];
      default: ;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= 4'd0;
      o_q     <= 8'h00;
      cnt_q   <= 8'h00;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // FIFO payload register.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; count_q alone decides
    // which entries are meaningful, so stale contents are never observed.
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: tb/tb_dec3_8_seq.sv
// Testbench for dec3_8_seq: three instances (HOLD = 2, 3, 1) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_dec3_8_seq;

  localparam int NDUT = 3;
`ifdef DEC3_8_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Y;
  logic       rdy_w  [NDUT];
  logic [7:0] o_w    [NDUT];
  logic       busy_w [NDUT];
  logic [7:0] cnt_w  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dec3_8_seq #(.HOLD(g == 0 ? 2 : (g == 1 ? 3 : 1))) u_dut (
      .clk   (clk),
      .rst   (rst),
      .Y     (Y),
      .ready (rdy_w[g]),
      .O     (o_w[g]),
      .busy  (busy_w[g]),
      .cnt   (cnt_w[g])
    );
  end

  // Reference model: a queue of waiting codes plus the code on display.
  int mq    [NDUT][$];
  int cur   [NDUT];
  int left  [NDUT];
  bit shown [NDUT];
  bit gap   [NDUT];
  int mcnt  [NDUT];

  int tests = 0;
  int fails = 0;

  function automatic int hold_of(int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      mq[d].delete();
      cur[d]   = 0;
      left[d]  = 0;
      shown[d] = 1'b0;
      gap[d]   = 1'b0;
      mcnt[d]  = 0;
    end
  endtask

  // One clock edge of the specified behaviour for every instance.
  task automatic model_edge(input logic [3:0] y);
    for (int d = 0; d < NDUT; d++) begin
      bit acc;
      bit go_gap;
      acc = y[3] && (mq[d].size() < 2);
      if (shown[d] && left[d] > 0) begin
        left[d]--;
      end else begin
        go_gap   = GAP_EN && shown[d];
        shown[d] = 1'b0;
        gap[d]   = go_gap;
        if (!go_gap && mq[d].size() > 0) begin
          cur[d]   = mq[d].pop_front();
          shown[d] = 1'b1;
          left[d]  = hold_of(d) - 1;
          mcnt[d]  = (mcnt[d] + 1) % 256;
        end
      end
      if (acc) mq[d].push_back(int'(y[2:0]));
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      logic [7:0] exp_o;
      exp_o = shown[d] ? (8'h01 << cur[d]) : 8'h00;
      check({tag, "_O"},     d, 32'(o_w[d]),    32'(exp_o));
      check({tag, "_cnt"},   d, 32'(cnt_w[d]),  32'(mcnt[d] % 256));
      check({tag, "_busy"},  d, 32'(busy_w[d]), 32'(shown[d] || gap[d] || mq[d].size() > 0));
      check({tag, "_ready"}, d, 32'(rdy_w[d]),  32'(mq[d].size() < 2));
      check({tag, "_onehot"}, d, 32'($onehot0(o_w[d])), 32'd1);
    end
  endtask

  task automatic step(input logic [3:0] y, input string tag);
    Y = y;
    @(posedge clk);
    model_edge(y);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    check_all("reset");
  endtask

  initial begin
    rst = 1'b1;
    Y   = 4'b0000;

    // Reset, with a valid code present to confirm reset wins over accept.
    Y = 4'b1011;
    do_reset();

    // Single code 5 with HOLD=2 on instance 0.
    check("req22_ready", 0, 32'(rdy_w[0]), 32'd1);
    step(4'b1101, "req22");
    check("req22_latency", 0, 32'(o_w[0]), 32'h00);
    step(4'b0000, "req22");
    check("req22_o1", 0, 32'(o_w[0]), 32'h20);
    step(4'b0000, "req22");
    check("req22_o2", 0, 32'(o_w[0]), 32'h20);
    step(4'b0000, "req22");
    check("req22_o_end", 0, 32'(o_w[0]), 32'h00);
    check("req22_cnt", 0, 32'(cnt_w[0]), 32'd1);
    check("req22_busy", 0, 32'(busy_w[0]), 32'd0);
    for (int i = 0; i < 4; i++) step(4'b0000, "drain22");

    // Codes 0 then 7 on consecutive edges.
    do_reset();
    step(4'b1000, "req23");
    step(4'b1111, "req23");
    check("req23_first", 0, 32'(o_w[0]), 32'h01);
    step(4'b0000, "req23");
    check("req23_hold", 0, 32'(o_w[0]), 32'h01);
    step(4'b0000, "req23");
    check("req23_switch", 0, 32'(o_w[0]), GAP_EN ? 32'h00 : 32'h80);
    for (int i = 0; i < 10; i++) step(4'b0000, "req23");

    // Codes 3,4,5,6 presented every edge: fill, drop, and ordering.
    do_reset();
    for (int i = 0; i < 12; i++) step({1'b1, 3'(3 + (i % 4))}, "req24");
    for (int i = 0; i < 20; i++) step(4'b0000, "req24_drain");

    // Invalid codes only.
    do_reset();
    for (int i = 0; i < 20; i++) step({1'b0, 3'($urandom)}, "req25");
    for (int d = 0; d < NDUT; d++) begin
      check("req25_cnt", d, 32'(cnt_w[d]), 32'd0);
      check("req25_busy", d, 32'(busy_w[d]), 32'd0);
      check("req25_O", d, 32'(o_w[d]), 32'h00);
    end

    // Reset in the middle of a hold with one entry buffered.
    do_reset();
    step(4'b1001, "req26");
    step(4'b1010, "req26");
    check("req26_busy_pre", 0, 32'(busy_w[0]), 32'd1);
    check("req26_ready_pre", 0, 32'(rdy_w[0]), 32'd1);
    Y = 4'b1100;
    do_reset();
    check("req26_O", 0, 32'(o_w[0]), 32'h00);
    check("req26_cnt", 0, 32'(cnt_w[0]), 32'd0);
    check("req26_busy", 0, 32'(busy_w[0]), 32'd0);
    check("req26_ready", 0, 32'(rdy_w[0]), 32'd1);
    for (int i = 0; i < 10; i++) step(4'b0000, "req26_after");

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) step(4'($urandom), "rand");
    for (int i = 0; i < 10; i++) step(4'b0000, "rand_drain");

    // Counter wrap on the HOLD=1 instance: 256 codes then one more.
    do_reset();
    for (int i = 0; i < 256; i++) step({1'b1, 3'($urandom)}, "req27");
    for (int i = 0; i < 4; i++) step(4'b0000, "req27_drain");
    check("req27_wrap", 2, 32'(cnt_w[2]), 32'h00);
    step({1'b1, 3'($urandom)}, "req27");
    for (int i = 0; i < 3; i++) step(4'b0000, "req27_drain");
    check("req27_after", 2, 32'(cnt_w[2]), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dec3_8_seq.md
DEC3_8_SEQ -- requirements
Module: dec3_8_seq

Interface
REQ-001 SHALL have parameter: HOLD, default 2, number of cycles each one-hot output is held; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: Y  input  4  encoded request; Y[3] = valid flag, Y[2:0] = index (0..7), same format as the 8-to-3 priority encoder output.
REQ-005 SHALL have port: ready  output  1  high when a code presented on Y is accepted this edge.
REQ-006 SHALL have port: O  output  8  registered one-hot decoded output; all-zero when nothing is being driven.
REQ-007 SHALL have port: busy  output  1  high while state is not IDLE or the buffer is non-empty.
REQ-008 SHALL have port: cnt  output  8  count of codes driven onto O since reset.

Function
REQ-009 SHALL accept Y on a rising edge when Y[3]=1 and ready=1; Y[3]=0 is never accepted and never changes state.
REQ-010 SHALL hold accepted codes in a 2-entry FIFO in arrival order; ready = (entries < 2), derived from registered state only, with no combinational path from Y.
REQ-011 SHALL implement states IDLE, HOLD and GAP; GAP is reachable only per REQ-021.
REQ-012 IDLE: when the FIFO is non-empty, SHALL pop the head, set O = 1 << index, load the hold counter with HOLD-1, increment cnt, and go to HOLD, all on the same edge.
REQ-013 Latency: a code accepted at edge N into an empty FIFO while IDLE SHALL appear on O after edge N+1.
REQ-014 HOLD: SHALL keep O constant for exactly HOLD cycles, decrementing the counter each edge; at counter 0, SHALL go to IDLE with O=0.
REQ-015 Back-to-back: at counter 0 with the FIFO non-empty, SHALL pop the next code directly into HOLD with no zero cycle (macro off).
REQ-016 Simultaneous push and pop on the same edge SHALL be legal; entry count is unchanged and order is preserved.
REQ-017 When FIFO is full, ready=0 and Y SHALL be ignored even if the same edge pops an entry.
REQ-018 cnt SHALL be 8-bit modulo and wrap 255 -> 0.
REQ-019 O SHALL never have more than one bit set.

Reset
REQ-020 On rst=1 at an edge: state=IDLE, FIFO empty, O=8'h00, cnt=8'h00, hold counter=0, busy=0, ready=1 after that edge; SHALL abort any hold in progress with no completion, and rst SHALL take priority over a simultaneous accept.

Configuration
REQ-021 Macro DEC3_8_GAP_EN: when defined, at counter 0 of HOLD the block SHALL enter GAP for exactly one cycle with O=0, then behave as IDLE; when undefined, GAP does not exist and REQ-015 applies.

Verification
REQ-022 Reset then Y=4'b1101 for one cycle, HOLD=2 -> ready=1 at accept; O=8'b00100000 for 2 cycles starting one edge after accept; then O=0, cnt=1, busy=0.
REQ-023 Y=4'b1000 then 4'b1111 on consecutive edges, HOLD=2, macro off -> O=8'h01 for 2 cycles, then 8'h80 for 2 cycles with no zero cycle; same stimulus with DEC3_8_GAP_EN -> exactly one O=8'h00 cycle between them.
REQ-024 Y held at valid codes 3, 4, 5, 6 every edge, HOLD=3 -> ready drops after 2 entries are buffered; every code appears on O in order; dropped codes never appear on O; O is always one-hot or zero.
REQ-025 Y=4'b0xxx for 20 cycles -> O stays 8'h00, cnt=0, busy=0.
REQ-026 rst asserted mid-HOLD with one entry buffered -> after the edge O=0, cnt=0, busy=0, ready=1; the buffered code is never output.
REQ-027 256 single codes, HOLD=1 -> cnt reads 8'h00 after the 256th, 8'h01 after the 257th.
